// File: rtl/round_result_collector.sv
// round_result_collector
//   Counts the enabled rounds of one cipher run, captures the settled 32-bit
//   result and streams it MSB byte first over a valid/ready byte interface.
//   A run whose length differs from ROUNDS (or a new run that starts while a
//   result is still draining) raises a sticky error flag.
//   Optional feature macro: ROUND_COLLECTOR_PARITY_EN adds o_out_par, the even
//   parity of o_out_byte, registered together with the byte.
module round_result_collector #(
    parameter int ROUNDS = 32,
    parameter int CNT_W  = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_global_en,
    input  logic       i_en,
    input  logic [7:0] i_in_1,
    input  logic [7:0] i_in_2,
    input  logic [7:0] i_in_3,
    input  logic [7:0] i_in_4,
    output logic [7:0] o_out_byte,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
`ifdef ROUND_COLLECTOR_PARITY_EN
    ,
    output logic       o_out_par
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ROUNDS_CNT = CNT_W'(ROUNDS);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_res;
    logic [1:0]       r_idx;
    logic             r_en_d;
    logic             r_global_en_d;
    logic [7:0]       r_out_byte;
    logic             r_out_valid;
    logic             r_done;
    logic             r_err;

    logic             w_load;
    logic [7:0]       w_byte_next;
    logic [1:0]       w_idx_next;
    logic             w_en_rise;
    logic             w_accept;

    assign w_en_rise  = i_en && !r_en_d;
    assign w_accept   = r_out_valid && i_out_ready;
    assign w_idx_next = r_idx + 2'd1;

    // Decide when the output byte register takes a new value and which value:
    // the first byte comes straight from IN_1 on the run-ending edge, later
    // bytes come from the captured result as each byte is accepted.
    always_comb begin
        w_load      = 1'b0;
        w_byte_next = r_out_byte;
        if (i_global_en) begin
            if (r_state == RUN && !i_en && r_cnt == ROUNDS_CNT) begin
                w_load      = 1'b1;
                w_byte_next = i_in_1;
            end else if (r_state == DRAIN && w_accept && r_idx != 2'd3) begin
                w_load = 1'b1;
                case (w_idx_next)
                    2'd1:    w_byte_next = r_res[23:16];
                    2'd2:    w_byte_next = r_res[15:8];
                    default: w_byte_next = r_res[7:0];
                endcase
            end
        end
    end

    // Main controller: round counting, result capture, drain handshake,
    // abort on GLOBAL_EN low and sticky error handling.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_res         <= '0;
            r_idx         <= 2'd0;
            r_en_d        <= 1'b0;
            r_global_en_d <= 1'b0;
            r_out_byte    <= 8'd0;
            r_out_valid   <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_en_d        <= i_en;
            r_global_en_d <= i_global_en;
            r_done        <= 1'b0;
            if (w_load) begin
                r_out_byte <= w_byte_next;
            end
            if (!i_global_en) begin
                // Abort: drop everything except the sticky error.
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_cnt       <= '0;
                r_idx       <= 2'd0;
            end else begin
                // A fresh GLOBAL_EN rising edge starts with a clean error flag;
                // assignments further down may still set it on the same edge.
                if (!r_global_en_d) begin
                    r_err <= 1'b0;
                end
                case (r_state)
                    IDLE: begin
                        if (w_en_rise) begin
                            r_state <= RUN;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    RUN: begin
                        r_res <= {i_in_1, i_in_2, i_in_3, i_in_4};
                        if (i_en) begin
                            if (r_cnt != CNT_MAX) begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                        end else if (r_cnt == ROUNDS_CNT) begin
                            r_state     <= DRAIN;
                            r_idx       <= 2'd0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    DRAIN: begin
                        // A new run while draining is an overrun; it is not started.
                        if (w_en_rise) begin
                            r_err <= 1'b1;
                        end
                        if (w_accept) begin
                            if (r_idx == 2'd3) begin
                                r_out_valid <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= IDLE;
                                r_cnt       <= '0;
                                r_idx       <= 2'd0;
                            end else begin
                                r_idx <= w_idx_next;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef ROUND_COLLECTOR_PARITY_EN
    logic r_out_par;

    // Parity is registered with the byte so it holds under backpressure too.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_par <= 1'b0;
        end else if (w_load) begin
            r_out_par <= ^w_byte_next;
        end
    end

    assign o_out_par = r_out_par;
`endif

    assign o_out_byte  = r_out_byte;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_round_result_collector.sv
// Testbench for round_result_collector: directed scenarios plus randomized
// runs. Expected bytes are queued when a run is issued; a negedge monitor pops
// and compares them whenever a byte is handed over (valid && ready).
module tb_round_result_collector;

    localparam int ROUNDS = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       gen;
    logic       en;
    logic [7:0] in1, in2, in3, in4;
    logic       rdy;
    logic [7:0] o_out_byte;
    logic       o_out_valid;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
`ifdef ROUND_COLLECTOR_PARITY_EN
    logic       o_out_par;
`endif

    int         checks = 0;
    int         errors = 0;
    int         done_seen = 0;
    logic [7:0] exp_q[$];
    bit         exp_err = 1'b0;
    bit         rand_rdy = 1'b0;
    bit         chk_hold = 1'b1;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_byte = 8'd0;

    round_result_collector #(.ROUNDS(ROUNDS), .CNT_W(6)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_global_en (gen),
        .i_en        (en),
        .i_in_1      (in1),
        .i_in_2      (in2),
        .i_in_3      (in3),
        .i_in_4      (in4),
        .o_out_byte  (o_out_byte),
        .o_out_valid (o_out_valid),
        .i_out_ready (rdy),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
`ifdef ROUND_COLLECTOR_PARITY_EN
        ,
        .o_out_par   (o_out_par)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: byte scoreboard, backpressure hold check, DONE pulse counting.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (chk_hold && prev_valid && !prev_ready) begin
                checks++;
                if (!(o_out_valid === 1'b1 && o_out_byte === prev_byte)) begin
                    errors++;
                    $display("FAIL hold: valid=%0b byte=%02h, required valid=1 byte=%02h",
                             o_out_valid, o_out_byte, prev_byte);
                end
            end
            if (o_out_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %02h, required no byte", o_out_byte);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (o_out_byte !== e) begin
                        errors++;
                        $display("FAIL byte: got %02h, required %02h", o_out_byte, e);
                    end else begin
                        $display("t=%0t byte accepted %02h", $time, o_out_byte);
                    end
`ifdef ROUND_COLLECTOR_PARITY_EN
                    checks++;
                    if (o_out_par !== ^e) begin
                        errors++;
                        $display("FAIL parity: got %0b, required %0b for byte %02h",
                                 o_out_par, ^e, e);
                    end
`endif
                end
            end
            if (o_done) done_seen++;
            prev_valid = o_out_valid;
            prev_ready = rdy;
            prev_byte  = o_out_byte;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_in();
        {in1, in2, in3, in4} = $urandom;
    endtask

    // Hold EN for n cycles, then present the final result on the EN-low edge.
    task automatic drive_rounds(input int n, input logic [31:0] data);
        if (n == ROUNDS) begin
            exp_q.push_back(data[31:24]);
            exp_q.push_back(data[23:16]);
            exp_q.push_back(data[15:8]);
            exp_q.push_back(data[7:0]);
        end else begin
            exp_err = 1'b1;
        end
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            rand_in();
            tick();
        end
        en = 1'b0;
        {in1, in2, in3, in4} = data;
        tick();
        rand_in();
    endtask

    task automatic finish_run(input bit good, input int d0);
        int k;
        k = 0;
        while ((o_busy || o_out_valid) && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: busy=%0b valid=%0b, required idle", o_busy, o_out_valid);
        end
        tick();
        chk("done_count", 32'(done_seen - d0), good ? 32'd1 : 32'd0);
        chk("err", {31'd0, o_err}, {31'd0, exp_err});
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("t=%0t run finished good=%0b err=%0b", $time, good, o_err);
    endtask

    task automatic do_run(input int n, input logic [31:0] data);
        int d0;
        d0 = done_seen;
        drive_rounds(n, data);
        finish_run(n == ROUNDS, d0);
    endtask

    task automatic clear_err();
        gen = 1'b0;
        tick();
        gen = 1'b1;
        tick();
        exp_err = 1'b0;
        chk("err_clear", {31'd0, o_err}, 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        logic [7:0] bytes_de[4];
        bytes_de[0] = 8'hDE; bytes_de[1] = 8'hAD; bytes_de[2] = 8'hBE; bytes_de[3] = 8'hEF;

        rst = 1'b1; gen = 1'b0; en = 1'b0; rdy = 1'b1;
        {in1, in2, in3, in4} = 32'd0;
        tick(); tick();
        chk("reset_valid", {31'd0, o_out_valid}, 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_byte", {24'd0, o_out_byte}, 32'd0);
        rst = 1'b0;
        gen = 1'b1;
        tick(); tick();

        // Test 2: nominal run, bytes on 4 consecutive cycles, DONE after the last.
        d0 = done_seen;
        drive_rounds(ROUNDS, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            chk("t2_valid", {31'd0, o_out_valid}, 32'd1);
            chk("t2_byte", {24'd0, o_out_byte}, {24'd0, bytes_de[k]});
`ifdef ROUND_COLLECTOR_PARITY_EN
            chk("t2_par", {31'd0, o_out_par}, {31'd0, ^bytes_de[k]});
`endif
            tick();
        end
        chk("t2_done", {31'd0, o_done}, 32'd1);
        chk("t2_valid_off", {31'd0, o_out_valid}, 32'd0);
        finish_run(1'b1, d0);

        // Test 3: backpressure while byte 1 is presented.
        d0 = done_seen;
        drive_rounds(ROUNDS, 32'hDEADBEEF);
        chk("t3_byte0", {24'd0, o_out_byte}, 32'hDE);
        tick();
        chk("t3_byte1", {24'd0, o_out_byte}, 32'hAD);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_byte", {24'd0, o_out_byte}, 32'hAD);
            chk("t3_hold_valid", {31'd0, o_out_valid}, 32'd1);
        end
        rdy = 1'b1;
        tick();
        chk("t3_byte2", {24'd0, o_out_byte}, 32'hBE);
        tick();
        chk("t3_byte3", {24'd0, o_out_byte}, 32'hEF);
        tick();
        chk("t3_done_at_7", {31'd0, o_done}, 32'd1);
        finish_run(1'b1, d0);

        // Test 4: short and long runs flag ERR and emit nothing; re-enable clears.
        do_run(31, $urandom);
        do_run(33, $urandom);
        clear_err();

        // Test 5a: abort after byte 0 accepted.
        chk_hold = 1'b0;
        d0 = done_seen;
        drive_rounds(ROUNDS, 32'h12345678);
        chk("t5_valid", {31'd0, o_out_valid}, 32'd1);
        tick();
        gen = 1'b0;
        rdy = 1'b0;
        tick();
        chk("t5_abort_valid", {31'd0, o_out_valid}, 32'd0);
        chk("t5_abort_busy", {31'd0, o_busy}, 32'd0);
        tick(); tick();
        chk("t5_no_done", 32'(done_seen - d0), 32'd0);
        chk("t5_remaining", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        gen = 1'b1;
        rdy = 1'b1;
        tick();
        chk_hold = 1'b1;
        exp_err = 1'b0;

        // Test 5b: EN rising edge during DRAIN is an overrun; drain still completes.
        rdy = 1'b0;
        d0 = done_seen;
        drive_rounds(ROUNDS, 32'hCAFEF00D);
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        exp_err = 1'b1;
        chk("t5_overrun_err", {31'd0, o_err}, 32'd1);
        chk("t5_overrun_busy", {31'd0, o_busy}, 32'd1);
        rdy = 1'b1;
        finish_run(1'b1, d0);
        clear_err();

        // Randomized runs with random backpressure.
        rand_rdy = 1'b1;
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0) clear_err();
            case ($urandom_range(0, 5))
                0: n = 31;
                1: n = 33;
                2: n = 70;
                default: n = ROUNDS;
            endcase
            do_run(n, $urandom);
        end
        rand_rdy = 1'b0;
        rdy = 1'b1;

        // Test 1: asynchronous reset mid-cycle while draining with ERR set.
        do_run(31, $urandom);
        rdy = 1'b0;
        drive_rounds(ROUNDS, 32'hA5A5A5A5);
        chk("t1_pre_valid", {31'd0, o_out_valid}, 32'd1);
        chk("t1_pre_err", {31'd0, o_err}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t1_byte", {24'd0, o_out_byte}, 32'd0);
        chk("t1_valid", {31'd0, o_out_valid}, 32'd0);
        chk("t1_busy", {31'd0, o_busy}, 32'd0);
        chk("t1_done", {31'd0, o_done}, 32'd0);
        chk("t1_err", {31'd0, o_err}, 32'd0);
        exp_q.delete();
        exp_err = 1'b0;
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        tick();
        do_run(ROUNDS, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
